// File: rtl/avalon_key165_reader_pkg.sv
// rtl/avalon_key165_reader_pkg.sv - shared register map and scan FSM encoding for the 74HC165 reader
package avalon_key165_reader_pkg;

  localparam logic [2:0] ADDR_KEYS_LO = 3'd0;
  localparam logic [2:0] ADDR_KEYS_HI = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CTRL    = 3'd3;

  localparam int STATUS_CHANGED_BIT = 0;
  localparam int STATUS_BUSY_BIT    = 1;
  localparam int CTRL_SCAN_EN_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    UPDATE   = 3'd5
  } key165_state_e;

endpackage

// File: rtl/avalon_key165_reader_if.sv
// rtl/avalon_key165_reader_if.sv - 8-bit Avalon-MM register port of the 74HC165 reader
interface avalon_key165_reader_if;
  logic [2:0] address;
  logic [7:0] writedata;
  logic       write;
  logic       read;
  logic       chipselect;
  logic [7:0] readdata;

  modport master (
    output address, writedata, write, read, chipselect,
    input  readdata
  );

  modport slave (
    input  address, writedata, write, read, chipselect,
    output readdata
  );
endinterface

// File: rtl/key165_shifter.sv
// rtl/key165_shifter.sv - 74HC165 chain scan engine: load/settle/shift FSM, QH synchroniser, shift register
module key165_shifter
  import avalon_key165_reader_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                qh,
  output logic                pl_n,
  output logic                cp,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] word
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(NUM_BITS + 1);

  key165_state_e        state_q, state_d;
  logic [DIV_W-1:0]     div_q;
  logic [BIT_W-1:0]     bit_q;
  logic [NUM_BITS-1:0]  sr_q;
  logic [1:0]           qh_sync_q;
  logic                 phase_end;
  logic                 last_bit;

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_q == BIT_W'(NUM_BITS - 1));
  assign busy      = (state_q != IDLE);
  assign word      = sr_q;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = LOAD;
      LOAD:     if (phase_end) state_d = SETTLE;
      SETTLE:   if (phase_end) state_d = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_d = last_bit ? UPDATE : SHIFT_LO;
      UPDATE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Board pins are registered from the next state so they line up with state_q without glitches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      qh_sync_q <= '0;
      pl_n      <= 1'b1;
      cp        <= 1'b0;
    end else begin
      state_q   <= state_d;
      qh_sync_q <= {qh_sync_q[0], qh};
      pl_n      <= (state_d != LOAD);
      cp        <= (state_d == SHIFT_HI);

      if (state_d != state_q)
        div_q <= '0;
      else if (state_q != IDLE)
        div_q <= div_q + 1'b1;

      if (state_q == LOAD)
        bit_q <= '0;
      else if (state_q == SHIFT_HI && phase_end)
        bit_q <= bit_q + 1'b1;

      // First bit out of the chain ends up in the MSB after NUM_BITS shifts.
      if (state_q == SHIFT_LO && phase_end)
        sr_q <= {sr_q[NUM_BITS-2:0], qh_sync_q[1]};
    end
  end

endmodule

// File: rtl/avalon_key165_reader.sv
// rtl/avalon_key165_reader.sv - Avalon-MM 74HC165 key scanner; KEY165_IRQ_EN enables the change interrupt
module avalon_key165_reader
  import avalon_key165_reader_pkg::*;
#(
  parameter int NUM_BITS    = 16,
  parameter int CLK_DIV     = 4,
  parameter int SCAN_PERIOD = 50000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  avalon_key165_reader_if.slave        bus,
  output logic                         irq,
  output logic                         PL_N,
  output logic                         CP,
  input  logic                         QH
);

  localparam int CNT_W = $clog2(SCAN_PERIOD + 1);

  logic [CNT_W-1:0]    period_cnt_q;
  logic [NUM_BITS-1:0] keys_q;
  logic [NUM_BITS-1:0] word;
  logic                changed_q;
  logic                scan_en_q;
  logic                irq_en;
  logic                busy;
  logic                done;
  logic                start;
  logic                bus_rd;
  logic                ctrl_wr;
  logic                status_rd;
  logic [15:0]         keys_ext;
  logic                unused_wdata;

  assign bus_rd       = bus.chipselect && bus.read;
  assign ctrl_wr      = bus.chipselect && bus.write && (bus.address == ADDR_CTRL);
  assign status_rd    = bus_rd && (bus.address == ADDR_STATUS);
  assign start        = scan_en_q && !busy && (period_cnt_q == CNT_W'(SCAN_PERIOD - 1));
  assign unused_wdata = &{1'b0, bus.writedata[7:1]};

  key165_shifter #(
    .NUM_BITS (NUM_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .qh      (QH),
    .pl_n    (PL_N),
    .cp      (CP),
    .busy    (busy),
    .done    (done),
    .word    (word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_cnt_q <= '0;
      keys_q       <= '0;
      changed_q    <= 1'b0;
      scan_en_q    <= 1'b1;
    end else begin
      if (!scan_en_q || busy || start)
        period_cnt_q <= '0;
      else
        period_cnt_q <= period_cnt_q + 1'b1;

      if (done)
        keys_q <= word;

      // A differing scan beats a clearing status read in the same cycle.
      if (done && (word != keys_q))
        changed_q <= 1'b1;
      else if (status_rd)
        changed_q <= 1'b0;

      if (ctrl_wr)
        scan_en_q <= bus.writedata[CTRL_SCAN_EN_BIT];
    end
  end

`ifdef KEY165_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr)
        irq_en_q <= bus.writedata[CTRL_IRQ_EN_BIT];
      irq_q <= changed_q && irq_en_q;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    keys_ext = '0;
    for (int i = 0; i < NUM_BITS && i < 16; i++)
      keys_ext[i] = keys_q[i];
  end

  always_comb begin
    bus.readdata = '0;
    if (bus_rd) begin
      case (bus.address)
        ADDR_KEYS_LO: bus.readdata = keys_ext[7:0];
        ADDR_KEYS_HI: bus.readdata = keys_ext[15:8];
        ADDR_STATUS: begin
          bus.readdata[STATUS_CHANGED_BIT] = changed_q;
          bus.readdata[STATUS_BUSY_BIT]    = busy;
        end
        ADDR_CTRL: begin
          bus.readdata[CTRL_SCAN_EN_BIT] = scan_en_q;
          bus.readdata[CTRL_IRQ_EN_BIT]  = irq_en;
        end
        default: bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_key165_reader.sv
// tb/tb_avalon_key165_reader.sv - scoreboard bench for avalon_key165_reader with a 74HC165 chain model
module tb_avalon_key165_reader;

  localparam int NB       = 16;
  localparam int CD       = 2;
  localparam int SP       = 10;
  localparam int SCAN_LEN = (2 + 2 * NB) * CD + 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  logic PL_N;
  logic CP;
  logic QH;

  avalon_key165_reader_if bus ();

  avalon_key165_reader #(
    .NUM_BITS    (NB),
    .CLK_DIV     (CD),
    .SCAN_PERIOD (SP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .PL_N    (PL_N),
    .CP      (CP),
    .QH      (QH)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // 74HC165 chain: parallel load on PL_N fall, shift toward QH on each CP rise.
  logic [15:0] hc_word = '0;
  logic [15:0] hc_sr   = '0;
  always @(negedge PL_N) hc_sr = hc_word;
  always @(posedge CP) if (PL_N === 1'b1) hc_sr = {hc_sr[14:0], 1'b0};
  assign QH = hc_sr[15];

  logic [15:0] keys_m;
  logic        changed_m;
  logic        scan_en_m;
  logic        irq_en_m;
  logic [7:0]  exp_q[$];
  logic        irq_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a, input logic busy);
    case (a)
      3'd0:    return keys_m[7:0];
      3'd1:    return keys_m[15:8];
      3'd2:    return {6'b0, busy, changed_m};
      3'd3:    return {6'b0, irq_en_m, scan_en_m};
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (irq === 1'b1) irq_seen = 1'b1;
    if (bus.chipselect === 1'b1 && bus.read === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
      else check("readdata", {24'b0, bus.readdata}, {24'b0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic end_bus();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic start_read(input logic [2:0] a, input logic busy);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    exp_q.push_back(model_read(a, busy));
    if (a == 3'd2) changed_m = 1'b0;
  endtask

  task automatic start_write(input logic [2:0] a, input logic [7:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    if (a == 3'd3) begin
      scan_en_m = d[0];
`ifdef KEY165_IRQ_EN
      irq_en_m  = d[1];
`endif
    end
  endtask

  task automatic bus_read(input logic [2:0] a);
    tick();
    start_read(a, 1'b0);
    tick();
    end_bus();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    tick();
    start_write(a, d);
    tick();
    end_bus();
  endtask

  task automatic wait_load(output int n);
    n = 0;
    while (PL_N !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (PL_N !== 1'b0) check("load_timeout", 32'(PL_N), 32'd0);
  endtask

  // Entered in the first LOAD cycle; leaves in the first cycle after UPDATE.
  task automatic run_scan(input logic [15:0] word, input int wr_at, input int rd_at);
    int   pl_low   = 1;
    int   cp_rises = 0;
    int   cp_high  = 0;
    logic cp_prev  = 1'b0;
    for (int i = 1; i <= SCAN_LEN; i++) begin
      tick();
      if (i == wr_at + 1 || i == rd_at + 1) end_bus();
      if (i == wr_at) start_write(3'd3, 8'h00);
      if (i == rd_at) start_read(3'd2, 1'b1);
      if (PL_N === 1'b0) pl_low++;
      if (CP === 1'b1) cp_high++;
      if (CP === 1'b1 && !cp_prev) cp_rises++;
      cp_prev = CP;
    end
    check("pl_n_low_cycles", pl_low, CD);
    check("cp_pulses", cp_rises, NB);
    check("cp_high_cycles", cp_high, NB * CD);
    if (word != keys_m) changed_m = 1'b1;
    keys_m = word;
  endtask

  task automatic scan(input logic [15:0] word, input int wr_at, input int rd_at);
    int n;
    hc_word = word;
    wait_load(n);
    run_scan(word, wr_at, rd_at);
    bus_read(3'd0);
    bus_read(3'd1);
    bus_read(3'd2);
  endtask

  initial begin
    int          n;
    int          lows;
    logic [15:0] w;

    bus.address    = '0;
    bus.writedata  = '0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.chipselect = 1'b0;
    keys_m         = '0;
    changed_m      = 1'b0;
    scan_en_m      = 1'b1;
    irq_en_m       = 1'b0;

    repeat (3) tick();
    check("reset_pl_n", 32'(PL_N), 32'd1);
    check("reset_cp", 32'(CP), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("idle_readdata", {24'b0, bus.readdata}, 32'd0);
    bus_read(3'd0);
    bus_read(3'd1);
    bus_read(3'd2);
    bus_read(3'd3);
    bus_read(3'd5);

    hc_word = 16'hA5C3;
    reset_n = 1'b1;
    wait_load(n);
    check("first_load_delay", n, SP);
    run_scan(16'hA5C3, 0, 0);
    bus_read(3'd0);
    bus_read(3'd1);
    bus_read(3'd2);

    scan(16'hA5C3, 0, 0);

    for (int k = 0; k < 6; k++) begin
      w = (k == 3) ? keys_m : 16'($urandom);
      scan(w, 0, 0);
    end

    scan(keys_m ^ 16'h8001, 0, SCAN_LEN - 1);

    scan(16'($urandom), 20, 0);
    lows = 0;
    repeat (5 * SP) begin
      tick();
      if (PL_N === 1'b0) lows++;
    end
    check("no_load_when_disabled", lows, 0);
    bus_read(3'd3);
    bus_write(3'd3, 8'h02);
    bus_read(3'd3);

`ifdef KEY165_IRQ_EN
    bus_write(3'd3, 8'h03);
    hc_word = 16'h0001;
    w = keys_m;
    wait_load(n);
    run_scan(16'h0001, 0, 0);
    check("irq_before_rise", 32'(irq), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'(w != 16'h0001));
    bus_read(3'd2);
    tick();
    check("irq_drop", 32'(irq), 32'd0);
    bus_write(3'd3, 8'h01);
`else
    bus_write(3'd3, 8'h01);
`endif

    scan(16'($urandom), 0, 0);

    hc_word = 16'($urandom);
    wait_load(n);
    n = 0;
    while (CP !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("reach_shift_hi", 32'(CP), 32'd1);
    reset_n = 1'b0;
    tick();
    check("reset_mid_pl_n", 32'(PL_N), 32'd1);
    check("reset_mid_cp", 32'(CP), 32'd0);
    keys_m    = '0;
    changed_m = 1'b0;
    scan_en_m = 1'b1;
    irq_en_m  = 1'b0;
    bus_read(3'd0);
    bus_read(3'd1);
    bus_read(3'd3);
    bus_read(3'd2);
    w       = 16'($urandom) | 16'h0100;
    hc_word = w;
    reset_n = 1'b1;
    wait_load(n);
    check("restart_load_delay", n, SP);
    run_scan(w, 0, 0);
    bus_read(3'd0);
    bus_read(3'd1);
    bus_read(3'd2);

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef KEY165_IRQ_EN
    check("irq_seen", 32'(irq_seen), 32'd1);
`else
    check("irq_never", 32'(irq_seen), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL global_timeout: actual running required finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
